// File: rtl/hyperbus_arbiter.sv
// rtl/hyperbus_arbiter.sv - round-robin burst arbiter/sequencer in front of a HyperBus leader controller
// Optional beat watchdog: define HYPERBUS_ARB_TIMEOUT_EN.
module hyperbus_arbiter #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int NREQ        = 2,
  parameter int LEN_WIDTH   = 8,
  parameter int MAX_BEATS   = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0]             req_reg,
  input  logic [NREQ*ADDR_LENGTH-1:0] req_adr,
  input  logic [NREQ*LEN_WIDTH-1:0]   req_len,
  output logic [NREQ-1:0]             req_ack,
  input  logic [NREQ*2*WIDTH-1:0]     req_wdat,
  input  logic [NREQ*(2*WIDTH/8)-1:0] req_wmask,
  output logic [NREQ-1:0]             req_wready,
  output logic [2*WIDTH-1:0]          req_rdat,
  output logic [NREQ-1:0]             req_rvalid,
  output logic [NREQ-1:0]             req_done,
  output logic [NREQ-1:0]             req_err,
  output logic [ADDR_LENGTH-1:0]      hb_adr,
  output logic                        hb_reg_space,
  output logic                        hb_wrq,
  output logic                        hb_rrq,
  output logic [2*WIDTH-1:0]          hb_dat,
  output logic [2*WIDTH/8-1:0]        hb_mask,
  input  logic                        hb_ready,
  input  logic [2*WIDTH-1:0]          hb_dat_i,
  input  logic                        hb_valid
);
  localparam int MW = 2*WIDTH/8;
  localparam int CW = $clog2(MAX_BEATS) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;
  state_t state, state_d;

  logic [PW-1:0]          rr_ptr, owner, grant_idx;
  logic                   grant_any;
  logic                   we_q, reg_q;
  logic [ADDR_LENGTH-1:0] adr_q;
  logic [LEN_WIDTH-1:0]   rem_q, len_g;
  logic [CW-1:0]          chunk_q, beat_q, chunk_c;
  logic [GW-1:0]          gap_q;
  logic                   beat, last_beat, abort, aborted, gap_end;

  // Descending scan so the closest index after rr_ptr is the one that sticks.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign len_g     = req_len[int'(grant_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign chunk_c   = (rem_q > LEN_WIDTH'(MAX_BEATS)) ? CW'(MAX_BEATS) : CW'(rem_q);
  assign beat      = (state == XFER) && (we_q ? hb_ready : hb_valid);
  assign last_beat = beat && ((beat_q + 1'b1) == chunk_q);
  assign gap_end   = (state == GAP) && (gap_q == GW'(GAP_CYCLES - 1));

`ifdef HYPERBUS_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q;
  logic          aborted_q;

  assign abort   = (state == XFER) && !beat && (wd_q == WW'(TIMEOUT - 1));
  assign aborted = aborted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      aborted_q <= 1'b0;
      req_err   <= '0;
    end else begin
      req_err <= '0;
      if (state == ISSUE)     wd_q <= '0;
      else if (state == XFER) wd_q <= beat ? '0 : wd_q + 1'b1;
      if (state == IDLE) aborted_q <= 1'b0;
      else if (abort) begin
        aborted_q      <= 1'b1;
        req_err[owner] <= 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign aborted = 1'b0;
  assign req_err = '0;
`endif

  always_comb begin
    state_d    = state;
    hb_dat     = '0;
    hb_mask    = '0;
    req_wready = '0;
    req_rvalid = '0;
    req_rdat   = '0;
    case (state)
      IDLE:    if (grant_any) state_d = ISSUE;
      ISSUE:   state_d = XFER;
      XFER:    if (last_beat || abort) state_d = GAP;
      GAP:     if (gap_end) state_d = (rem_q != '0 && !aborted) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
    if (state == XFER && we_q) begin
      hb_dat            = req_wdat[int'(owner)*2*WIDTH +: 2*WIDTH];
      hb_mask           = req_wmask[int'(owner)*MW +: MW];
      req_wready[owner] = beat;
    end else if (state != IDLE && we_q) begin
      // Controller may still pull a beat after the chunk: keep every byte masked.
      hb_mask = '1;
    end
    if (state == XFER && !we_q) begin
      req_rvalid[owner] = beat;
      if (beat) req_rdat = hb_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= PW'(NREQ - 1);
      owner        <= '0;
      we_q         <= 1'b0;
      reg_q        <= 1'b0;
      adr_q        <= '0;
      rem_q        <= '0;
      chunk_q      <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      hb_adr       <= '0;
      hb_reg_space <= 1'b0;
      hb_wrq       <= 1'b0;
      hb_rrq       <= 1'b0;
      req_ack      <= '0;
      req_done     <= '0;
    end else begin
      state    <= state_d;
      req_ack  <= '0;
      req_done <= '0;
      case (state)
        IDLE: if (grant_any) begin
          owner              <= grant_idx;
          rr_ptr             <= grant_idx;
          we_q               <= req_we[grant_idx];
          reg_q              <= req_reg[grant_idx];
          adr_q              <= req_adr[int'(grant_idx)*ADDR_LENGTH +: ADDR_LENGTH];
          rem_q              <= (len_g == '0) ? LEN_WIDTH'(1) : len_g;
          req_ack[grant_idx] <= 1'b1;
        end
        ISSUE: begin
          chunk_q      <= chunk_c;
          beat_q       <= '0;
          hb_adr       <= adr_q;
          hb_reg_space <= reg_q;
          hb_wrq       <= we_q;
          hb_rrq       <= !we_q;
        end
        XFER: begin
          if (beat) beat_q <= beat_q + 1'b1;
          if (last_beat || abort) begin
            hb_wrq <= 1'b0;
            hb_rrq <= 1'b0;
            gap_q  <= '0;
          end
          if (last_beat) begin
            rem_q <= rem_q - LEN_WIDTH'(chunk_q);
            adr_q <= adr_q + ADDR_LENGTH'(chunk_q);
          end
          if (abort) req_done[owner] <= 1'b1;
        end
        GAP: begin
          gap_q <= gap_q + 1'b1;
          if (gap_end && rem_q == '0 && !aborted) req_done[owner] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hyperbus_arbiter.sv
// tb/tb_hyperbus_arbiter.sv - scoreboard bench for hyperbus_arbiter
`timescale 1ns/1ps
module tb_hyperbus_arbiter;
  localparam int GAP  = 4;
  localparam int TOUT = 64;
  localparam int K_ACK = 0, K_WINR = 1, K_WINW = 2, K_RD = 3, K_WR = 4, K_MASK = 5, K_DONE = 6;

  typedef struct {
    int          kind;
    int          idx;
    logic [35:0] data;
  } ev_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [1:0]  req_valid = '0, req_we = '0, req_reg = '0;
  logic [63:0] req_adr = '0;
  logic [15:0] req_len = '0;
  logic [1:0]  req_ack;
  logic [31:0] req_wdat = '0;
  logic [3:0]  req_wmask = '0;
  logic [1:0]  req_wready, req_rvalid, req_done, req_err;
  logic [15:0] req_rdat;
  logic [31:0] hb_adr;
  logic        hb_reg_space, hb_wrq, hb_rrq;
  logic [15:0] hb_dat;
  logic [1:0]  hb_mask;
  logic        hb_ready = 1'b0, hb_valid = 1'b0;
  logic [15:0] hb_dat_i = '0;

  ev_t         exp_q[$];
  int          checks = 0, errors = 0, cyc = 0;
  int          win_cyc = 0, last_cyc = 0, hold_acks = 0, wptr = 0;
  logic        rd_en = 1'b1, post_ready = 1'b0, rrq_d = 1'b0, wrq_d = 1'b0;
  logic [15:0] rd_pat = 16'h1000, exp_rd = 16'h1000;
  logic [15:0] wtab_d [4] = '{16'hA1A1, 16'hB2B2, 16'hC3C3, 16'h0000};
  logic [1:0]  wtab_m [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  hyperbus_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_reg(req_reg), .req_adr(req_adr),
    .req_len(req_len), .req_ack(req_ack), .req_wdat(req_wdat), .req_wmask(req_wmask),
    .req_wready(req_wready), .req_rdat(req_rdat), .req_rvalid(req_rvalid),
    .req_done(req_done), .req_err(req_err), .hb_adr(hb_adr), .hb_reg_space(hb_reg_space),
    .hb_wrq(hb_wrq), .hb_rrq(hb_rrq), .hb_dat(hb_dat), .hb_mask(hb_mask),
    .hb_ready(hb_ready), .hb_dat_i(hb_dat_i), .hb_valid(hb_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic string kname(input int k);
    case (k)
      K_ACK:  return "ack";
      K_WINR: return "rrq_window";
      K_WINW: return "wrq_window";
      K_RD:   return "rvalid";
      K_WR:   return "wready";
      K_MASK: return "post_mask";
      default: return "done";
    endcase
  endfunction

  function automatic void push(input int k, input int i, input logic [35:0] d);
    ev_t e;
    e.kind = k; e.idx = i; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Expected events of one read burst: split into 16-beat windows, len 0 acts as 1.
  function automatic void push_read(input int i, input logic rg, input logic [31:0] adr, input int len);
    int rem = (len == 0) ? 1 : len;
    logic [31:0] a = adr;
    push(K_ACK, i, '0);
    while (rem > 0) begin
      int c = (rem > 16) ? 16 : rem;
      push(K_WINR, 0, {3'b0, rg, a});
      for (int b = 0; b < c; b++) begin
        push(K_RD, i, {20'b0, exp_rd});
        exp_rd++;
      end
      a += 32'(c);
      rem -= c;
    end
    push(K_DONE, i, '0);
  endfunction

  function automatic void chk(input int k, input int i, input logic [35:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected %s[%0d]: got data %h, required no event", kname(k), i, d);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != k || e.idx != i || e.data != d) begin
      errors++;
      $display("FAIL %s: got %s[%0d] data %h, required %s[%0d] data %h",
               kname(e.kind), kname(k), i, d, kname(e.kind), e.idx, e.data);
    end
  endfunction

  task automatic set_req(input int i, input logic we, input logic rg, input logic [31:0] adr, input logic [7:0] len);
    req_we[i]          = we;
    req_reg[i]         = rg;
    req_adr[i*32 +: 32] = adr;
    req_len[i*8 +: 8]   = len;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      for (int i = 0; i < 2; i++) begin
        if (req_ack[i]) begin
          if (hold_acks > 0) begin
            hold_acks--;
            if (hold_acks == 0) req_valid = '0;
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({req_ack, req_wready, req_rvalid, req_done, req_err, hb_wrq, hb_rrq, hb_adr,
         hb_reg_space, hb_dat, hb_mask, req_rdat} != '0) begin
      errors++;
      $display("FAIL %s: got ack=%b wready=%b rvalid=%b done=%b err=%b wrq=%b rrq=%b adr=%h mask=%b, required all 0",
               name, req_ack, req_wready, req_rvalid, req_done, req_err, hb_wrq, hb_rrq, hb_adr, hb_mask);
    end
  endtask

  // Controller model and requester 0 write-data source.
  initial begin
    logic rd_beat, wr_beat, wrq_was;
    forever begin
      @(negedge clk);
      rd_beat = hb_valid && hb_rrq;
      wr_beat = req_wready[0];
      wrq_was = hb_wrq;
      @(posedge clk); #1;
      if (rd_beat) rd_pat++;
      if (wr_beat && wptr < 3) wptr++;
      post_ready       = wrq_was && !hb_wrq;
      hb_dat_i         = rd_pat;
      hb_valid         = rd_en && hb_rrq && (cyc % 4 != 3);
      hb_ready         = (hb_wrq && (cyc % 3 != 2)) || post_ready;
      req_wdat[15:0]   = wtab_d[wptr];
      req_wmask[1:0]   = wtab_m[wptr];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) if (req_ack[i]) chk(K_ACK, i, '0);
      if (hb_rrq && !rrq_d) begin chk(K_WINR, 0, {3'b0, hb_reg_space, hb_adr}); win_cyc = cyc; end
      if (hb_wrq && !wrq_d) begin chk(K_WINW, 0, {3'b0, hb_reg_space, hb_adr}); win_cyc = cyc; end
      for (int i = 0; i < 2; i++) if (req_wready[i]) begin chk(K_WR, i, {18'b0, hb_mask, hb_dat}); last_cyc = cyc; end
      for (int i = 0; i < 2; i++) if (req_rvalid[i]) begin chk(K_RD, i, {20'b0, req_rdat}); last_cyc = cyc; end
      if (post_ready && hb_ready) chk(K_MASK, 0, {34'b0, hb_mask});
      for (int i = 0; i < 2; i++) begin
        if (req_done[i]) begin
          chk(K_DONE, i, {35'b0, req_err[i]});
          checks++;
          if (req_err[i]) begin
            if (cyc - win_cyc != TOUT || hb_rrq) begin
              errors++;
              $display("FAIL timeout_timing: got %0d cycles rrq=%b, required %0d cycles rrq=0", cyc - win_cyc, hb_rrq, TOUT);
            end
          end else if (cyc - last_cyc != GAP + 1) begin
            errors++;
            $display("FAIL gap_timing: got %0d cycles, required %0d", cyc - last_cyc, GAP + 1);
          end
        end
      end
    end
    rrq_d = hb_rrq;
    wrq_d = hb_wrq;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_outputs");
    rst = 1'b0;

    // Two reads contending from reset: requester 0 first.
    set_req(0, 1'b0, 1'b0, 32'h0000_0000, 8'd4);
    set_req(1, 1'b0, 1'b1, 32'h0000_0040, 8'd4);
    push_read(0, 1'b0, 32'h0, 4);
    push_read(1, 1'b1, 32'h40, 4);
    req_valid = 2'b11;
    drain(400);

    // Write burst of three beats, then masked post-chunk beat.
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 8'd3);
    push(K_ACK, 0, '0);
    push(K_WINW, 0, {4'b0, 32'h100});
    for (int b = 0; b < 3; b++) push(K_WR, 0, {18'b0, wtab_m[b], wtab_d[b]});
    push(K_MASK, 0, {34'b0, 2'b11});
    push(K_DONE, 0, '0);
    req_valid = 2'b01;
    drain(200);

    // Long read split into 16/16/8.
    set_req(0, 1'b0, 1'b0, 32'h0000_0000, 8'd40);
    push_read(0, 1'b0, 32'h0, 40);
    req_valid = 2'b01;
    drain(600);

    // Reset in the middle of a stalled read.
    rd_en = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0000_0300, 8'd8);
    push(K_ACK, 0, '0);
    push(K_WINR, 0, {4'b0, 32'h300});
    req_valid = 2'b01;
    drain(50);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (!hb_rrq) begin
      errors++;
      $display("FAIL rrq_before_reset: got %b, required 1", hb_rrq);
    end
    rst = 1'b1;
    #1;
    check_zero("mid_burst_reset");
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    rd_en = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0000_0010, 8'd1);
    set_req(1, 1'b0, 1'b0, 32'h0000_0020, 8'd1);
    push_read(0, 1'b0, 32'h10, 1);
    push_read(1, 1'b0, 32'h20, 1);
    req_valid = 2'b11;
    drain(200);

    // Both held valid: grants alternate; len 0 on requester 1 behaves as one beat.
    set_req(0, 1'b0, 1'b0, 32'h0000_0050, 8'd1);
    set_req(1, 1'b0, 1'b0, 32'h0000_0060, 8'd0);
    for (int r = 0; r < 2; r++) begin
      push_read(0, 1'b0, 32'h50, 1);
      push_read(1, 1'b0, 32'h60, 0);
    end
    hold_acks = 4;
    req_valid = 2'b11;
    drain(300);

`ifdef HYPERBUS_ARB_TIMEOUT_EN
    // Controller never returns data: watchdog aborts the burst.
    rd_en = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'h0000_0080, 8'd2);
    push(K_ACK, 0, '0);
    push(K_WINR, 0, {4'b0, 32'h80});
    push(K_DONE, 0, 36'd1);
    req_valid = 2'b01;
    drain(200);
    repeat (GAP + 6) @(posedge clk);
    rd_en = 1'b1;
`endif

    repeat (12) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
